fetch_sequencer: RTL

PC register and instruction-fetch engine: the producing end of the instr/pc_control interface consumed by the instruction decoder. Fetches one instruction at a time from instruction memory over a req/ack handshake and presents it with a valid/ready handshake. On each accepted instruction, samples the decoder's 3-bit pc_control to compute the next PC (sequential, J/JAL, JR/JALR, taken branch).

---
 rtl/fetch_pkg.sv | 46 ++++
 rtl/next_pc_calc.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared definitions for the fetch engine and the instruction
//               decoder: the next-PC select encodings the decoder drives on
//               pc_control, the fetch FSM state encoding, and small helpers
//               for the jump/branch target arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Next-PC select driven by the decoder. Codes 3'b100..3'b111 are not
  // assigned; the fetch engine treats them as sequential and flags an error.
  typedef logic [2:0] pc_control_t;

  localparam pc_control_t PC_SEQ    = 3'b000;
  localparam pc_control_t PC_JUMP   = 3'b001;
  localparam pc_control_t PC_JREG   = 3'b010;
  localparam pc_control_t PC_BRANCH = 3'b011;

  // Fetch FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Instruction words are 4 bytes; every PC advance is by this amount.
  localparam logic [31:0] PC_STEP = 32'd4;

  // J/JAL target: keep the 256 MB region of the delay-slot-free successor
  // (pc+4) and replace the low 28 bits with the word-aligned 26-bit index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    jump_target = {pc_plus4[31:28], index, 2'b00};
  endfunction

  // Branch target: sign-extended 16-bit word offset relative to pc+4.
  // Arithmetic wraps modulo 2^32 by construction of the 32-bit sum.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC selector. Given the successor address
//               of the current instruction, the instruction word itself, the
//               rs register value and the decoder's pc_control code, produces
//               the address of the next instruction to fetch and an error
//               strobe for misaligned register targets or unassigned codes.
// Ports       : pc_plus4   in  32  address of current instruction + 4
//               instr      in  32  current instruction word
//               rs_data    in  32  rs register value (JR/JALR target)
//               pc_control in   3  next-PC select from the decoder
//               next_pc    out 32  selected next fetch address
//               err        out  1  misaligned JR target / unknown select
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [2:0]  pc_control,
  output logic [31:0] next_pc,
  output logic        err
);

  // The opcode field is the decoder's business; only the immediate and
  // index fields matter for target arithmetic here.
  logic w_unused_opcode;
  assign w_unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    err     = 1'b0;
    case (pc_control)
      PC_SEQ: begin
        next_pc = pc_plus4;
      end
      PC_JUMP: begin
        next_pc = jump_target(pc_plus4, instr[25:0]);
      end
      PC_JREG: begin
        // The low two bits are forced to zero so the fetch stays word
        // aligned; a non-zero value there is still reported as an error.
        next_pc = {rs_data[31:2], 2'b00};
        err     = |rs_data[1:0];
      end
      PC_BRANCH: begin
        next_pc = branch_target(pc_plus4, instr[15:0]);
      end
      default: begin
        // Unassigned select codes fall back to sequential flow.
        next_pc = pc_plus4;
        err     = 1'b1;
      end
    endcase
  end

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : PC register and single-outstanding instruction fetch engine.
//               Fetches one word at a time over a req/ack memory handshake,
//               presents it to the decoder over valid/ready, and on each
//               accepted instruction samples pc_control/rs_data to step the
//               PC (sequential, jump, register jump or taken branch).
// Ports       : clk         in   1  system clock, rising edge
//               rst_n       in   1  asynchronous active-low reset
//               imem_req    out  1  fetch request, held until imem_ack
//               imem_addr   out 32  fetch address, stable while requesting
//               imem_ack    in   1  memory returns imem_rdata this cycle
//               imem_rdata  in  32  instruction word, valid with imem_ack
//               instr       out 32  current instruction to decoder
//               instr_valid out  1  instr/pc/pc_plus4 valid
//               instr_ready in   1  decoder accepts instr this cycle
//               pc          out 32  address of instr
//               pc_plus4    out 32  pc + 4 (link value)
//               pc_control  in   3  next-PC select, sampled on accept
//               rs_data     in  32  JR/JALR target, sampled on accept
//               fetch_err   out  1  sticky error flag, cleared by reset
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [2:0]  pc_control,
  input  logic [31:0] rs_data,
  output logic        fetch_err
);

  localparam logic [31:0] c_RESET_PC_PLUS4 = RESET_PC + PC_STEP;

  fetch_state_e r_state;
  logic         r_imem_req;
  logic [31:0]  r_imem_addr;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic [31:0]  r_pc;
  logic [31:0]  r_pc_plus4;
  logic         r_fetch_err;

  logic [31:0]  w_next_pc;
  logic [31:0]  w_next_pc_plus4;
  logic         w_next_err;
  logic         w_accept;

  // --------------------------------------------------------------------------
  // Next-PC selection. Only consulted on the accept edge, so pc_control and
  // rs_data are don't-care at every other time.
  // --------------------------------------------------------------------------
  next_pc_calc u_next_pc_calc (
    .pc_plus4   (r_pc_plus4),
    .instr      (r_instr),
    .rs_data    (rs_data),
    .pc_control (pc_control),
    .next_pc    (w_next_pc),
    .err        (w_next_err)
  );

  assign w_next_pc_plus4 = w_next_pc + PC_STEP;
  assign w_accept        = (r_state == ST_HOLD) && r_instr_valid && instr_ready;

  // --------------------------------------------------------------------------
  // Fetch FSM. All outputs are registered; imem_addr is loaded together with
  // the rising imem_req so it is already stable in the first request cycle.
  // An asserted reset clears imem_req asynchronously, abandoning any fetch
  // in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_pc          <= RESET_PC;
      r_pc_plus4    <= c_RESET_PC_PLUS4;
      r_fetch_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // First clock out of reset: start fetching at the reset PC.
          r_state     <= ST_REQ;
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
        end

        ST_REQ: begin
          // Acks arriving in any other state are simply not looked at.
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (w_accept) begin
            r_pc          <= w_next_pc;
            r_pc_plus4    <= w_next_pc_plus4;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_imem_addr   <= w_next_pc;
            r_state       <= ST_REQ;
            if (w_next_err) begin
              r_fetch_err <= 1'b1;
            end
          end
        end

        default: begin
          // Unreachable encoding: restart the fetch cleanly from IDLE.
          r_state       <= ST_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc_plus4;
  assign fetch_err   = r_fetch_err;

endmodule : fetch_sequencer
`default_nettype wire
